// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register: resolves branches/jumps from the ALU flags, drives the fetch
// redirect, and carries result, store data and control into MEM with branch statistics.
module ex_mem_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_ex_i,
    input  logic [XLEN-1:0]  res_alu_i,
    input  logic             z_alu_i,
    input  logic             n_alu_i,
    input  logic [XLEN-1:0]  pc_ex_i,
    input  logic [XLEN-1:0]  imm_ex_i,
    input  logic             is_branch_ex_i,
    input  logic [2:0]       br_type_ex_i,
    input  logic             jal_ex_i,
    input  logic             jalr_ex_i,
    input  logic [4:0]       rd_ex_i,
    input  logic             rf_wr_en_ex_i,
    input  logic             mem_rd_ex_i,
    input  logic             mem_wr_ex_i,
    input  logic [XLEN-1:0]  store_data_ex_i,
    input  logic             stall_mem_i,
    input  logic             flush_i,
    output logic             redirect_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             valid_mem_o,
    output logic [XLEN-1:0]  res_mem_o,
    output logic [XLEN-1:0]  store_data_mem_o,
    output logic [4:0]       rd_mem_o,
    output logic             rf_wr_en_mem_o,
    output logic             mem_rd_mem_o,
    output logic             mem_wr_mem_o,
    output logic             exc_mem_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] br_taken_cnt_o
);

    logic            adv;
    logic            taken;
    logic            xfer;
    logic            mis;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;

    // BLTU and BGEU both use n directly: the ALU inverts the flag for BGEU.
    always_comb begin
        taken = 1'b0;
        case (br_type_ex_i)
            3'b000:  taken = z_alu_i;
            3'b001:  taken = ~z_alu_i;
            3'b100:  taken = n_alu_i;
            3'b101:  taken = ~n_alu_i;
            3'b110:  taken = n_alu_i;
            3'b111:  taken = n_alu_i;
            default: taken = 1'b0;
        endcase
    end

    assign adv    = valid_ex_i & ~stall_mem_i & ~flush_i;
    assign target = jalr_ex_i ? (res_alu_i & ~XLEN'(1)) : (pc_ex_i + imm_ex_i);
    assign link   = pc_ex_i + XLEN'(4);
    assign xfer   = (is_branch_ex_i & taken) | jal_ex_i | jalr_ex_i;
    assign mis    = xfer & (target[1:0] != 2'b00);

    assign redirect_o    = ~reset & adv & xfer & ~mis;
    assign redirect_pc_o = target;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_mem_o      <= 1'b0;
            res_mem_o        <= '0;
            store_data_mem_o <= '0;
            rd_mem_o         <= '0;
            rf_wr_en_mem_o   <= 1'b0;
            mem_rd_mem_o     <= 1'b0;
            mem_wr_mem_o     <= 1'b0;
            exc_mem_o        <= 1'b0;
        end else if (flush_i || (!stall_mem_i && !valid_ex_i)) begin
            // Data fields are left alone on a kill or bubble; only the qualifiers matter.
            valid_mem_o    <= 1'b0;
            rf_wr_en_mem_o <= 1'b0;
            mem_rd_mem_o   <= 1'b0;
            mem_wr_mem_o   <= 1'b0;
            exc_mem_o      <= 1'b0;
        end else if (adv) begin
            valid_mem_o      <= 1'b1;
            res_mem_o        <= (jal_ex_i | jalr_ex_i) ? link : res_alu_i;
            store_data_mem_o <= store_data_ex_i;
            rd_mem_o         <= rd_ex_i;
            rf_wr_en_mem_o   <= rf_wr_en_ex_i & ~mis;
            mem_rd_mem_o     <= mem_rd_ex_i & ~mis;
            mem_wr_mem_o     <= mem_wr_ex_i & ~mis;
            exc_mem_o        <= mis;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            br_cnt_o       <= '0;
            br_taken_cnt_o <= '0;
        end else if (adv && is_branch_ex_i) begin
            if (br_cnt_o != {CNT_W{1'b1}})
                br_cnt_o <= br_cnt_o + 1'b1;
            if (taken && (br_taken_cnt_o != {CNT_W{1'b1}}))
                br_taken_cnt_o <= br_taken_cnt_o + 1'b1;
        end
    end

endmodule
